// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the run/pause/stop counter controller.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MAN  = 2'd1,
    RUN_AUTO = 2'd2,
    PAUSED   = 2'd3
  } state_t;

  typedef logic [1:0] speed_t;

  localparam speed_t SPEED_MIN = 2'd0;
  localparam speed_t SPEED_MAX = 2'd3;

  function automatic speed_t speed_up(input speed_t s);
    return (s == SPEED_MAX) ? SPEED_MAX : s + 2'd1;
  endfunction

  function automatic speed_t speed_down(input speed_t s);
    return (s == SPEED_MIN) ? SPEED_MIN : s - 2'd1;
  endfunction

endpackage

// File: rtl/speed_ramp.sv
// Timer speed register with manual up/down stepping and an automatic tick-driven ramp.
module speed_ramp
  import count_ctrl_pkg::*;
#(
  parameter int RAMP_TICKS = 10
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   inc,
  input  logic   dec,
  input  logic   step_tick,
  input  logic   auto,
  input  logic   load_zero,
  output speed_t speed
);

  localparam logic [7:0] RAMP_LAST = 8'(RAMP_TICKS - 1);

  logic [7:0] ramp_cnt;

  // load_zero wins over everything so a fresh auto run or a wrap always restarts the ramp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed    <= SPEED_MIN;
      ramp_cnt <= 8'd0;
    end else if (load_zero) begin
      speed    <= SPEED_MIN;
      ramp_cnt <= 8'd0;
    end else if (auto) begin
      if (step_tick) begin
        if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt <= 8'd0;
          speed    <= speed_up(speed);
        end else begin
          ramp_cnt <= ramp_cnt + 8'd1;
        end
      end
    end else if (inc && !dec) begin
      speed <= speed_up(speed);
    end else if (dec && !inc) begin
      speed <= speed_down(speed);
    end
  end

endmodule

// File: rtl/count_controller.sv
// Run/pause/stop sequencer for the timer + BCD counter pair: gates ticks,
// issues clears, and owns the timer speed (manual or auto ramp).
module count_controller
  import count_ctrl_pkg::*;
#(
  parameter int RAMP_TICKS  = 10,
  parameter bit HOLD_AT_MAX = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick_in,
  input  logic       count_max,
  output logic [1:0] speed_select,
  output logic       tick_out,
  output logic       clear_out,
  output logic [1:0] state_o,
  output logic       auto_mode
);

  state_t state, state_nx;
  state_t resume_st, resume_nx;
  logic   auto_nx, tick_nx, clear_nx;
  logic   inc, dec, step_tick, load_zero;

  always_comb begin
    state_nx  = state;
    resume_nx = resume_st;
    auto_nx   = auto_mode;
    tick_nx   = 1'b0;
    clear_nx  = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;
    step_tick = 1'b0;
    load_zero = 1'b0;
    case (state)
      IDLE: begin
        if (btn_start) begin
          state_nx  = auto_mode ? RUN_AUTO : RUN_MAN;
          clear_nx  = 1'b1;
          load_zero = auto_mode;
        end else if (btn_mode) begin
          auto_nx = ~auto_mode;
        end
        if (!auto_mode) begin
          inc = btn_up;
          dec = btn_down;
        end
      end
      RUN_MAN, RUN_AUTO: begin
        // Holding at 99: swallow the tick and stop without clearing the display.
        if (tick_in && count_max && HOLD_AT_MAX) begin
          state_nx = IDLE;
        end else begin
          tick_nx = tick_in;
          if (state == RUN_AUTO) begin
            step_tick = tick_in;
            load_zero = tick_in && count_max;
          end
          if (btn_start) begin
            state_nx  = PAUSED;
            resume_nx = state;
          end
        end
        if (state == RUN_MAN) begin
          inc = btn_up;
          dec = btn_down;
        end
      end
      PAUSED: begin
        if (btn_start) begin
          state_nx = resume_st;
        end else if (btn_mode) begin
          state_nx = IDLE;
          clear_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      resume_st <= RUN_MAN;
      auto_mode <= 1'b0;
      tick_out  <= 1'b0;
      clear_out <= 1'b0;
    end else begin
      state     <= state_nx;
      resume_st <= resume_nx;
      auto_mode <= auto_nx;
      tick_out  <= tick_nx & ~clear_nx;
      clear_out <= clear_nx;
    end
  end

  assign state_o = state;

  speed_ramp #(
    .RAMP_TICKS(RAMP_TICKS)
  ) u_speed_ramp (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (inc),
    .dec      (dec),
    .step_tick(step_tick),
    .auto     (state == RUN_AUTO),
    .load_zero(load_zero),
    .speed    (speed_select)
  );

endmodule

// File: tb/tb_count_controller.sv
// Directed bench for count_controller: hold-at-99 instance plus a wrap-at-99 instance.
module tb_count_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_start, btn_mode, btn_up, btn_down, tick_in, count_max;
  logic [1:0] speed_select, state_o, speed_w, state_w;
  logic       tick_out, clear_out, auto_mode, tick_w, clear_w, auto_w;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  count_controller #(.RAMP_TICKS(10), .HOLD_AT_MAX(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .btn_start(btn_start), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .tick_in(tick_in), .count_max(count_max),
    .speed_select(speed_select), .tick_out(tick_out), .clear_out(clear_out),
    .state_o(state_o), .auto_mode(auto_mode)
  );

  count_controller #(.RAMP_TICKS(10), .HOLD_AT_MAX(1'b0)) dut_w (
    .clk(clk), .reset_n(reset_n), .btn_start(btn_start), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .tick_in(tick_in), .count_max(count_max),
    .speed_select(speed_w), .tick_out(tick_w), .clear_out(clear_w),
    .state_o(state_w), .auto_mode(auto_w)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: present inputs for one sampling edge, then release at the next negedge
  task automatic drive(input logic s, input logic m, input logic u, input logic d, input logic t);
    btn_start = s; btn_mode = m; btn_up = u; btn_down = d; tick_in = t;
    @(negedge clk);
    btn_start = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; tick_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_start = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick_in = 1'b0; count_max = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_speed", 8'(speed_select), 8'd0);
    chk("rst_tick", 8'(tick_out), 8'd0);
    chk("rst_clear", 8'(clear_out), 8'd0);
    chk("rst_auto", 8'(auto_mode), 8'd0);
    chk("rst_w_state", 8'(state_w), 8'd0);

    // start manual run
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_state", 8'(state_o), 8'd1);
    chk("start_clear", 8'(clear_out), 8'd1);
    chk("start_tick", 8'(tick_out), 8'd0);
    @(negedge clk);
    chk("clear_1cyc", 8'(clear_out), 8'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("tick_lag", 8'(tick_out), 8'd1);
    @(negedge clk);
    chk("tick_1cyc", 8'(tick_out), 8'd0);

    // manual speed saturation
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("up_sat", 8'(speed_select), 8'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("up_down_same", 8'(speed_select), 8'd3);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("down_sat", 8'(speed_select), 8'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("speed_two", 8'(speed_select), 8'd2);

    // pause / resume
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pause_state", 8'(state_o), 8'd3);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("pause_tick", 8'(tick_out), 8'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pause_no_up", 8'(speed_select), 8'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_state", 8'(state_o), 8'd1);
    chk("resume_noclear", 8'(clear_out), 8'd0);
    chk("resume_speed", 8'(speed_select), 8'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stop_state", 8'(state_o), 8'd0);
    chk("stop_clear", 8'(clear_out), 8'd1);
    @(negedge clk);
    chk("stop_clear_end", 8'(clear_out), 8'd0);

    // auto ramp
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("auto_toggle", 8'(auto_mode), 8'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("auto_state", 8'(state_o), 8'd2);
    chk("auto_speed0", 8'(speed_select), 8'd0);
    chk("auto_clear", 8'(clear_out), 8'd1);
    ticks(9);
    chk("ramp_9", 8'(speed_select), 8'd0);
    ticks(1);
    chk("ramp_10", 8'(speed_select), 8'd1);
    ticks(10);
    chk("ramp_20", 8'(speed_select), 8'd2);
    chk("ramp_20_w", 8'(speed_w), 8'd2);

    // terminal count: hold stops at 99, wrap restarts the ramp
    count_max = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    count_max = 1'b0;
    chk("hold_tick", 8'(tick_out), 8'd0);
    chk("hold_state", 8'(state_o), 8'd0);
    chk("hold_noclear", 8'(clear_out), 8'd0);
    chk("wrap_tick", 8'(tick_w), 8'd1);
    chk("wrap_speed", 8'(speed_w), 8'd0);
    chk("wrap_state", 8'(state_w), 8'd2);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_state", 8'(state_o), 8'd2);
    chk("restart_clear", 8'(clear_out), 8'd1);
    chk("restart_speed", 8'(speed_select), 8'd0);
    ticks(30);
    chk("ramp_30", 8'(speed_select), 8'd3);
    ticks(10);
    chk("ramp_40", 8'(speed_select), 8'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("auto_no_down", 8'(speed_select), 8'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("auto_no_up", 8'(speed_select), 8'd3);

    // asynchronous reset between edges
    tick_in = 1'b1;
    @(posedge clk);
    #1 tick_in = 1'b0;
    chk("pre_rst_tick", 8'(tick_out), 8'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_state", 8'(state_o), 8'd0);
    chk("arst_speed", 8'(speed_select), 8'd0);
    chk("arst_tick", 8'(tick_out), 8'd0);
    chk("arst_clear", 8'(clear_out), 8'd0);
    chk("arst_auto", 8'(auto_mode), 8'd0);
    chk("arst_w_state", 8'(state_w), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
